// File: rtl/ws_inst_sequencer.sv
// Weight-stationary instruction sequencer: walks every kernel tile through
// weight load, weight feed, activation load, execute and OFIFO drain.
module ws_inst_sequencer #(
  parameter int          col      = 8,
  parameter int          len_nij  = 36,
  parameter int          len_kij  = 9,
  parameter logic [10:0] x_base   = 11'h000,
  parameter logic [10:0] w_base   = 11'h400,
  parameter logic [10:0] p_base   = 11'h000,
  parameter int          exec_pad = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [34:0] inst,
  output logic        busy,
  output logic        done,
  output logic [3:0]  kij
);

  localparam logic [34:0] IDLE_INST = 35'h1_800C_0000;

  typedef enum logic [2:0] {
    S_IDLE, S_LD_W, S_FEED_W, S_LD_X, S_EXEC, S_DRAIN, S_DONE
  } state_t;

  state_t      state, state_n;
  logic [15:0] t, t_n;
  logic [3:0]  kij_n;
  logic        rd_n;
  logic [34:0] inst_n;

  function automatic logic [10:0] addr11(input logic [31:0] v);
    return v[10:0];
  endfunction

  always_comb begin
    state_n = state;
    t_n     = t + 16'd1;
    kij_n   = kij;
    rd_n    = 1'b0;
    case (state)
      S_IDLE: begin
        t_n = '0;
        if (start) begin
          state_n = S_LD_W;
          kij_n   = '0;
        end
      end
      S_LD_W:   if (t == 16'(col - 1))                 begin state_n = S_FEED_W; t_n = '0; end
      S_FEED_W: if (t == 16'(2 * col))                 begin state_n = S_LD_X;   t_n = '0; end
      S_LD_X:   if (t == 16'(len_nij - 1))             begin state_n = S_EXEC;   t_n = '0; end
      S_EXEC:   if (t == 16'(len_nij + exec_pad - 1))  begin state_n = S_DRAIN;  t_n = '0; end
      S_DRAIN: begin
        t_n = t;
        if (t == 16'(len_nij)) begin
          t_n = '0;
          if (kij == 4'(len_kij - 1)) begin
            state_n = S_DONE;
          end else begin
            state_n = S_LD_W;
            kij_n   = kij + 4'd1;
          end
        // Only re-read after a gap cycle: the core sees our read one cycle late.
        end else if (ofifo_valid && !inst[6]) begin
          rd_n = 1'b1;
          t_n  = t + 16'd1;
        end
      end
      default: begin
        state_n = S_IDLE;
        t_n     = '0;
      end
    endcase
  end

  // The instruction word is encoded from the next-state view so it is registered alongside it.
  always_comb begin
    inst_n = IDLE_INST;
    case (state_n)
      S_LD_W: begin
        inst_n[19]   = 1'b0;
        inst_n[17:7] = addr11(32'(w_base) + 32'(kij_n) * 32'(col) + 32'(t_n));
        inst_n[2]    = 1'b1;
      end
      S_FEED_W: begin
        inst_n[3] = 1'b1;
        inst_n[0] = 1'b1;
      end
      S_LD_X: begin
        inst_n[19]   = 1'b0;
        inst_n[17:7] = addr11(32'(x_base) + 32'(t_n));
        inst_n[2]    = 1'b1;
      end
      S_EXEC: begin
        inst_n[3] = 1'b1;
        inst_n[1] = 1'b1;
      end
      S_DRAIN: begin
        if (rd_n) begin
          inst_n[32]    = 1'b0;
          inst_n[31]    = 1'b0;
          inst_n[30:20] = addr11(32'(p_base) + 32'(kij) * 32'(len_nij) + 32'(t));
          inst_n[6]     = 1'b1;
        end
      end
      default: inst_n = IDLE_INST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      t     <= '0;
      kij   <= '0;
      inst  <= IDLE_INST;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      t     <= t_n;
      kij   <= kij_n;
      inst  <= inst_n;
      busy  <= (state_n != S_IDLE) && (state_n != S_DONE);
      done  <= (state_n == S_DONE);
    end
  end

endmodule

// File: tb/tb_ws_inst_sequencer.sv
// Directed bench for ws_inst_sequencer: single-tile and full-run schedules,
// drain stall, start-while-busy and mid-run reset.
module tb_ws_inst_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, start1 = 1'b0;
  logic        valid = 1'b1, valid1 = 1'b1;
  logic [34:0] inst, inst1;
  logic        busy, busy1, done, done1;
  logic [3:0]  kij, kij1;

  int checks = 0;
  int errors = 0;

  localparam logic [34:0] IDLE_W = 35'h1_800C_0000;

  always #5 clk = ~clk;

  ws_inst_sequencer #(.col(8), .len_nij(36), .len_kij(9), .x_base(11'h000),
    .w_base(11'h400), .p_base(11'h000), .exec_pad(2)) dut (
    .clk(clk), .reset(reset), .start(start), .ofifo_valid(valid),
    .inst(inst), .busy(busy), .done(done), .kij(kij));

  ws_inst_sequencer #(.col(8), .len_nij(36), .len_kij(1), .x_base(11'h000),
    .w_base(11'h400), .p_base(11'h000), .exec_pad(2)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .ofifo_valid(valid1),
    .inst(inst1), .busy(busy1), .done(done1), .kij(kij1));

  function automatic logic [34:0] word(input logic cp, input logic wp, input logic [10:0] ap,
                                       input logic cx, input logic wx, input logic [10:0] ax,
                                       input logic ofrd, input logic l0rd, input logic l0wr,
                                       input logic exe, input logic ld);
    return {2'b00, cp, wp, ap, cx, wx, ax, ofrd, 2'b00, l0rd, l0wr, exe, ld};
  endfunction

  function automatic logic [34:0] ld_word(input int a);
    return word(1, 1, 11'd0, 0, 1, 11'(a), 0, 0, 1, 0, 0);
  endfunction
  function automatic logic [34:0] feed_word();
    return word(1, 1, 11'd0, 1, 1, 11'd0, 0, 1, 0, 0, 1);
  endfunction
  function automatic logic [34:0] exec_word();
    return word(1, 1, 11'd0, 1, 1, 11'd0, 0, 1, 0, 1, 0);
  endfunction
  function automatic logic [34:0] rd_word(input int a);
    return word(0, 0, 11'(a), 1, 1, 11'd0, 1, 0, 0, 0, 0);
  endfunction

  // Expected single-tile word at cycle c after start (cycle 1 = first LD_W).
  function automatic logic [34:0] exp_single(input int c);
    if (c <= 8)  return ld_word(11'h400 + c - 1);
    if (c <= 25) return feed_word();
    if (c <= 61) return ld_word(c - 26);
    if (c <= 99) return exec_word();
    if (c <= 171 && ((c - 100) % 2 == 1)) return rd_word((c - 101) / 2);
    return IDLE_W;
  endfunction

  // Fixed fields must hold on every cycle; pmem stays disabled except on reads.
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (inst[34] || inst[33] || inst[5] || inst[4] || (!inst[6] && inst[32] !== 1'b1)) begin
        errors++;
        $display("FAIL fixed_bits main inst=%h", inst);
      end
      checks++;
      if (inst1[34] || inst1[33] || inst1[5] || inst1[4] || (!inst1[6] && inst1[32] !== 1'b1)) begin
        errors++;
        $display("FAIL fixed_bits single inst=%h", inst1);
      end
    end
  end

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++;
    if (inst !== IDLE_W) begin errors++; $display("FAIL reset_inst got %h want %h", inst, IDLE_W); end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
    checks++;
    if (kij !== 4'd0) begin errors++; $display("FAIL reset_kij got %0d want 0", kij); end
    checks++;
    if (inst1 !== IDLE_W || busy1 !== 1'b0 || done1 !== 1'b0) begin
      errors++; $display("FAIL reset_single got %h %b %b want %h 0 0", inst1, busy1, done1, IDLE_W);
    end
  endtask

  task automatic test_single_tile();
    start1 = 1'b1;
    for (int c = 1; c <= 175; c++) begin
      @(negedge clk);
      start1 = 1'b0;
      checks++;
      if (inst1 !== exp_single(c)) begin
        errors++; $display("FAIL single_inst c=%0d got %h want %h", c, inst1, exp_single(c));
      end
      checks++;
      if (busy1 !== (c <= 171)) begin errors++; $display("FAIL single_busy c=%0d got %b want %b", c, busy1, c <= 171); end
      checks++;
      if (done1 !== (c == 172)) begin errors++; $display("FAIL single_done c=%0d got %b want %b", c, done1, c == 172); end
    end
  endtask

  task automatic test_full_run();
    int done_cnt = 0;
    valid = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 1560; c++) begin
      @(negedge clk);
      start = (c == 12);
      if (done) done_cnt++;
      if (c == 20 || c == 26) begin
        checks++;
        if (kij !== 4'd0 || inst !== (c == 20 ? feed_word() : ld_word(0))) begin
          errors++; $display("FAIL start_in_feed c=%0d got kij=%0d inst=%h", c, kij, inst);
        end
      end
      if (c >= 1369 && c <= 1376) begin
        checks++;
        if (inst !== ld_word(11'h440 + c - 1369) || kij !== 4'd8) begin
          errors++; $display("FAIL tile8_ldw c=%0d got %h kij=%0d want %h", c, inst, kij, ld_word(11'h440 + c - 1369));
        end
      end
      if (c >= 1469 && c <= 1539 && ((c - 1469) % 2 == 0)) begin
        checks++;
        if (inst !== rd_word(288 + (c - 1469) / 2)) begin
          errors++; $display("FAIL tile8_rd c=%0d got %h want %h", c, inst, rd_word(288 + (c - 1469) / 2));
        end
      end
      if (c == 1539 || c == 1540) begin
        checks++;
        if (busy !== (c == 1539) || done !== (c == 1540)) begin
          errors++; $display("FAIL full_end c=%0d got busy=%b done=%b", c, busy, done);
        end
      end
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL done_count got %0d want 1", done_cnt); end
  endtask

  task automatic test_drain_stall();
    int idx = 0;
    int stall = 0;
    valid = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 600 && idx < 36; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (stall > 0) begin
        checks++;
        if (inst[6]) begin errors++; $display("FAIL stall_read c=%0d got read addr %0d want none", c, inst[30:20]); end
        if (stall == 1) valid = 1'b1;
        stall--;
      end else if (inst[6]) begin
        checks++;
        if (inst[30:20] !== 11'(idx)) begin
          errors++; $display("FAIL stall_addr got %0d want %0d", inst[30:20], idx);
        end
        idx++;
        if (idx == 5) begin
          valid = 1'b0;
          stall = 11;
        end
      end
    end
    checks++;
    if (idx != 36) begin errors++; $display("FAIL stall_timeout got %0d reads want 36", idx); end
  endtask

  task automatic test_mid_reset();
    bit found = 0;
    valid = 1'b1;
    for (int c = 0; c < 1500 && !found; c++) begin
      @(negedge clk);
      if (kij == 4'd4 && inst[1]) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL reach_tile4_exec got timeout want exec of tile 4"); end
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (inst !== IDLE_W || busy !== 1'b0 || kij !== 4'd0 || done !== 1'b0) begin
      errors++; $display("FAIL mid_reset got inst=%h busy=%b kij=%0d done=%b", inst, busy, kij, done);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (inst !== IDLE_W || busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle got %h busy=%b", inst, busy); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (inst !== ld_word(11'h400) || busy !== 1'b1 || kij !== 4'd0) begin
      errors++; $display("FAIL restart got inst=%h busy=%b kij=%0d want %h 1 0", inst, busy, kij, ld_word(11'h400));
    end
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_full_run();
    repeat (3) @(negedge clk);
    test_drain_stall();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ws_inst_sequencer.md
# ws_inst_sequencer

Hardware sequencer that generates the 35-bit `inst` bus for `core` in weight-stationary mode, replacing bench-driven instruction sequencing. On `start` it runs the full kernel loop of `len_kij` tiles. Each tile has these phases: weights from xmem to L0, weights into the array, activations from xmem to L0, execute, and drain OFIFO into pmem. Sits directly upstream of `core`; xmem (activations and all weights) is preloaded by the host before `start`.

## Interface
- `col`, 8: array columns = weight rows per tile
- `len_nij`, 36: activation rows per tile and psums drained per tile
- `len_kij`, 9: kernel tiles per run
- `x_base`, 11'h000: xmem base address of activations
- `w_base`, 11'h400: xmem base of weights; tile k occupies `w_base + k*col` .. `+col-1`
- `p_base`, 11'h000: pmem base; tile k psums at `p_base + k*len_nij + n`
- `exec_pad`, 2: extra execute cycles after the last activation

Ports:
- `clk` input 1: clock
- `reset` input 1: synchronous, active-high
- `start` input 1: one-cycle pulse, sampled only in IDLE
- `ofifo_valid` input 1: from core, OFIFO has data
- `inst` output 35: registered instruction to core
  - [34] mode, [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem
  - [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem
  - [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load
- `busy` output 1: high from first command cycle through last drain cycle
- `done` output 1: one-cycle pulse after the final tile drains
- `kij` output 4: current tile index

## Operation
- Idle word (`IDLE_INST`) = 35'h1_800C_0000: CEN/WEN for both memories = 1, everything else 0.
- Bits [34], [33], [5] and [4] are always 0 (WS mode, no accumulate, IFIFO unused).
- State machine: IDLE -> LD_W -> FEED_W -> LD_X -> EXEC -> DRAIN, then either LD_W (next tile) or DONE -> IDLE.
- A single phase counter `t` clears on every state entry.
- IDLE: `inst` = IDLE_INST. On `start`=1, set `kij`=0 and go to LD_W.
- LD_W, `col` cycles: CEN_xmem=0, WEN_xmem=1, A_xmem=`w_base+kij*col+t`, l0_wr=1.
- FEED_W, `2*col+1` cycles: l0_rd=1, load=1, xmem disabled.
- LD_X, `len_nij` cycles: CEN_xmem=0, WEN_xmem=1, A_xmem=`x_base+t`, l0_wr=1.
- EXEC, `len_nij+exec_pad` cycles: l0_rd=1, execute=1.
- DRAIN issues one read per eligible cycle:
  - A read (ofifo_rd=1, CEN_pmem=0, WEN_pmem=0, A_pmem=`p_base+kij*len_nij+t`) is issued in cycle n+1 iff ofifo_valid=1 in cycle n and no read was issued in cycle n. This rules out over-read with the one-cycle instruction lag.
  - `t` increments per read. Otherwise the drain fields hold idle values.
  - After read number `len_nij`: if `kij==len_kij-1`, go to DONE; else increment `kij` and go to LD_W.
- DONE, 1 cycle: `done`=1, `inst`=IDLE_INST, then IDLE.
- Address arithmetic is 11-bit and wraps modulo 2048; the parameter choice is responsible for avoiding overlap.
- `start` while busy is ignored.
- `reset` at any time: next edge gives state=IDLE, `inst`=IDLE_INST, `busy`=0, `done`=0, `kij`=0, `t`=0. No partial command survives.

## Timing
- Reset values: `inst`=35'h1_800C_0000, `busy`=0, `done`=0, `kij`=0.
- All outputs are registered. `inst` changes only on `clk` rising edges.
- `start` high at edge E: the first LD_W command appears on `inst` right after E, and `busy` rises at the same time.
- Fixed cycles per tile: `col + 2*col+1 + len_nij + len_nij+exec_pad`. With defaults that is 8+17+36+38 = 99 cycles.
- Drain takes at least `2*len_nij` cycles per tile (72 with defaults).
- Minimum run with defaults: 9*(99+72)+1 = 1540 cycles from `start` to `done`.
- `done` and `busy` falling occur on the same edge.
- ofifo_valid dropping mid-drain stalls DRAIN indefinitely. There is no timeout; `t` is held.

## Test plan
- Reset: hold `reset` 3 cycles mid-EXEC of tile 4. Expect `inst`=35'h1_800C_0000, `busy`=0 and `kij`=0 next cycle. A new `start` then restarts at A_xmem=11'h400.
- Single tile (`len_kij`=1, `ofifo_valid` tied to 1):
  - 8 LD_W cycles with A_xmem 0x400..0x407, then 17 load cycles, then 36 l0_wr cycles with A_xmem 0..35, then 38 execute cycles.
  - Then 36 reads on alternate cycles with A_pmem 0..35.
  - `done` at cycle 172.
- Full run with defaults and `ofifo_valid`=1: tile 8 uses A_xmem 0x440..0x447 and A_pmem 288..323; `done` pulses exactly once, 1540 cycles after `start`.
- Drain stall: drop `ofifo_valid` for 10 cycles after read 5. Expect no reads during the stall and A_pmem resuming at 5 with no gaps or duplicates.
- `start` pulsed during FEED_W: ignored; `kij` and the state sequence are unchanged.
- Bits [34], [33], [5] and [4] are 0, and CEN_pmem=1, on every cycle outside DRAIN reads (checked by assertion).
